// File: rtl/divider_pkg.sv
// Shared state encoding, iteration constants and strobe decode for the divider controller.
// The CHECK state exists only when DIVCTRL_ZERO_CHECK_EN is defined.
package divider_pkg;

    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CLEAR,
`ifdef DIVCTRL_ZERO_CHECK_EN
        CHECK,
`endif
        SHIFT,
        TRIAL,
        RESULT,
        DONE
    } state_t;

    typedef struct packed {
        logic enable_op1;
        logic enable_op2;
        logic load_a;
        logic load_b;
        logic load_m;
        logic enable_sub;
        logic enable_zero;
        logic load_result;
    } ctrl_t;

    // Moore part of the slice strobes for a given state; TRIAL's LoadM/Increment are added by the top.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.enable_op1 = 1'b1;
                c.enable_op2 = 1'b1;
                c.load_a     = 1'b1;
                c.load_b     = 1'b1;
            end
            CLEAR: begin
                c.enable_zero = 1'b1;
                c.load_m      = 1'b1;
            end
`ifdef DIVCTRL_ZERO_CHECK_EN
            CHECK: c.enable_zero = 1'b1;
`endif
            SHIFT: begin
                c.load_m = 1'b1;
                c.load_a = 1'b1;
            end
            TRIAL:   c.enable_sub  = 1'b1;
            RESULT:  c.load_result = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/divider_control.sv
// Sequencer for an 8-slice restoring divider: fetch, clear, 8 shift/trial iterations, result.
// Define DIVCTRL_ZERO_CHECK_EN to add the divide-by-zero CHECK state and the Error flag.
module divider_control
    import divider_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Test,
    input  logic Overflow,
    input  logic nBorrowOut,
    output logic EnableOp1,
    output logic EnableOp2,
    output logic LoadA,
    output logic LoadB,
    output logic LoadM,
    output logic EnableSub,
    output logic EnableZero,
    output logic Increment,
    output logic LoadResult,
    output logic Busy,
    output logic Done,
    output logic Error
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl_q;
    logic             busy_q;
    logic             done_q;
    logic             last_iter;
    logic             run;

    assign last_iter = (cnt_q == CNT_W'(ITER_COUNT - 1));
    assign run       = ~Test;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = FETCH;
            FETCH:   state_d = CLEAR;
`ifdef DIVCTRL_ZERO_CHECK_EN
            CLEAR:   state_d = CHECK;
            CHECK:   state_d = Overflow ? DONE : SHIFT;
`else
            CLEAR:   state_d = SHIFT;
`endif
            SHIFT:   state_d = TRIAL;
            TRIAL:   state_d = last_iter ? RESULT : SHIFT;
            RESULT:  state_d = DONE;
            DONE:    state_d = Start ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan mode freezes every register; strobes are additionally masked below.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (run) begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
            busy_q  <= (state_d != IDLE) && (state_d != DONE);
            done_q  <= (state_d == DONE);
            if (state_q == TRIAL) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (state_d == FETCH) begin
                cnt_q <= '0;
            end
        end
    end

`ifdef DIVCTRL_ZERO_CHECK_EN
    logic error_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else if (run) begin
            if (state_d == FETCH) begin
                error_q <= 1'b0;
            end else if ((state_q == CHECK) && Overflow) begin
                error_q <= 1'b1;
            end
        end
    end

    assign Error = error_q;
`else
    logic unused_overflow;
    assign unused_overflow = Overflow;
    assign Error           = 1'b0;
`endif

    // TRIAL commits the subtraction and the quotient bit only when the MSB slice did not borrow.
    assign EnableOp1  = ctrl_q.enable_op1 & run;
    assign EnableOp2  = ctrl_q.enable_op2 & run;
    assign LoadA      = ctrl_q.load_a & run;
    assign LoadB      = ctrl_q.load_b & run;
    assign LoadM      = (ctrl_q.load_m | (ctrl_q.enable_sub & nBorrowOut)) & run;
    assign EnableSub  = ctrl_q.enable_sub & run;
    assign EnableZero = ctrl_q.enable_zero & run;
    assign Increment  = ctrl_q.enable_sub & nBorrowOut & run;
    assign LoadResult = ctrl_q.load_result & run;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: doc/divider_control.md
DIVIDER_CONTROL -- requirements
Module: divider_control

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port Start, input, 1 bit: request a division; sampled only in IDLE or DONE.
REQ-004 SHALL have port Test, input, 1 bit: scan mode; freezes the FSM while the slice chain shifts.
REQ-005 SHALL have port Overflow, input, 1 bit: divisor-zero flag from the slice chain; valid only while EnableZero=1.
REQ-006 SHALL have port nBorrowOut, input, 1 bit: borrow-out of the MSB slice; 1 means the trial subtraction did not borrow.
REQ-007 SHALL have ports EnableOp1, EnableOp2, LoadA, LoadB, LoadM, EnableSub, EnableZero, Increment and LoadResult, each output, 1 bit: bitslice control strobes, shared by all 8 slices.
REQ-008 SHALL have port Busy, output, 1 bit: a division is in progress.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port Error, output, 1 bit: the last division was aborted for divide-by-zero.

Function
REQ-011 SHALL implement an FSM with states IDLE, FETCH, CLEAR, CHECK (macro only), SHIFT, TRIAL, RESULT and DONE, plus a 3-bit iteration counter.
REQ-012 In IDLE, SHALL drive all strobes 0 and Busy=0; Start=1 → FETCH.
REQ-013 In FETCH, SHALL assert EnableOp1, EnableOp2, LoadA and LoadB (dividend→A, divisor→B) for 1 cycle → CLEAR; SHALL clear Error and the counter.
REQ-014 In CLEAR, SHALL assert EnableZero and LoadM (remainder M cleared) for 1 cycle → CHECK if the macro is defined, else SHIFT.
REQ-015 In SHIFT, SHALL assert LoadM and LoadA with EnableSub=0 (M:A shifted left 1 bit) for 1 cycle → TRIAL.
REQ-016 In TRIAL, SHALL assert EnableSub=1 and SHALL drive LoadM=Increment=nBorrowOut combinationally (Mealy), so M loads M−B and the quotient LSB is set only when there is no borrow.
REQ-017 On leaving TRIAL, SHALL increment the counter: counter=7 → RESULT, else → SHIFT; the counter wraps 7→0.
REQ-018 In RESULT, SHALL assert LoadResult for 1 cycle → DONE.
REQ-019 In DONE, SHALL drive Done=1 and Busy=0; Start=1 → FETCH (back-to-back operation), else → IDLE.
REQ-020 Busy SHALL be 1 in every state except IDLE and DONE; Start while Busy=1 SHALL be ignored.
REQ-021 Latency: with Start sampled at edge 0, Done SHALL be high in cycle 20 without the macro and in cycle 21 with it.
REQ-022 While Test=1, SHALL hold state and counter, force all strobes to 0, and hold Busy, Done and Error; on Test=0, SHALL resume the held state.
REQ-023 If Reset and Test are both 1, Reset SHALL win.

Reset
REQ-024 Reset=1 at any edge, including mid-division, SHALL on the next edge set the state to IDLE, the counter to 0 and Error to 0, and drive all strobes, Busy and Done to 0.
REQ-025 Start SHALL be ignored on any edge where Reset=1.

Configuration
REQ-026 With DIVCTRL_ZERO_CHECK_EN defined: the CHECK state SHALL exist and assert EnableZero for 1 cycle.
- Overflow=1 in CHECK → DONE with Error=1, no iterations.
- Overflow=0 in CHECK → SHIFT.
REQ-027 Without DIVCTRL_ZERO_CHECK_EN: CHECK SHALL be absent, Error SHALL be tied to 0, and Overflow SHALL be unused.

Structure
REQ-028 Package divider_pkg SHALL hold the state enum, ITER_COUNT=8 and CNT_W=3; the bitslice integration wrapper SHALL import the same package.
REQ-029 SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-030 Single Start pulse, nBorrowOut held 1 → Increment high in all 8 TRIAL cycles; LoadResult in cycle 19; Done high only in cycle 20 (no macro).
REQ-031 Integration with 8 bitslices: dividend 100, divisor 7 → Quotient 14, Remainder 2 after LoadResult; dividend 255, divisor 1 → Quotient 255, Remainder 0.
REQ-032 Macro defined, divisor 0 (Overflow=1 in CHECK) → Done in cycle 4 with Error=1, no SHIFT cycles; a subsequent Start clears Error in FETCH.
REQ-033 Reset pulsed in cycle 10 of a division → IDLE in cycle 11, all outputs 0; a new Start then completes normally in 20 cycles.
REQ-034 Test=1 for cycles 5–7 → strobes 0 during those cycles, state held, Done delayed to cycle 23.
REQ-035 Start held high continuously → Start is ignored while Busy; DONE goes directly to FETCH; a second Done arrives 20 cycles after the first.
